counter_stim_gen: RTL and testbench

Upstream stimulus stage for the 2-bit up/down counter. It takes a raw, bouncy push-button and a raw direction switch, synchronizes and debounces them, and produces the counter's `en` (one-cycle pulse per accepted press) and `d` (direction, held stable) inputs. It sits between board I/O and the counter, with `en`/`d` wired directly to the counter's ports.

---
 rtl/counter_stim_gen.sv | 153 +++++++++++++++
 tb/tb_counter_stim_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/counter_stim_gen.sv
// counter_stim_gen: upstream stimulus stage for the 2-bit up/down counter.
// Synchronizes and debounces a raw push-button and a raw direction switch, and
// produces a one-cycle enable pulse per accepted press plus a held direction.
// Optional feature macro: STIM_REPEAT_EN (auto-repeat pulses while held).
module counter_stim_gen #(
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic dir_in,
    output logic en,
    output logic d,
    output logic pressed
);

    localparam int DBW = $clog2(DB_CYCLES) + 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [DBW-1:0] DB_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] btn_sync;
    logic [SYNC_STAGES-1:0] dir_sync;
    logic btn_s;
    logic dir_s;

    logic [DBW-1:0] db_cnt;
    logic [DBW-1:0] db_cnt_next;
    logic en_next;
    logic d_next;
    logic pressed_next;

`ifdef STIM_REPEAT_EN
    localparam int RPW = $clog2(REPEAT_CYCLES);
    localparam logic [RPW-1:0] REP_LAST = RPW'(REPEAT_CYCLES - 1);

    logic [RPW-1:0] rep_cnt;
    logic [RPW-1:0] rep_cnt_next;
`endif

    assign btn_s = btn_sync[SYNC_STAGES-1];
    assign dir_s = dir_sync[SYNC_STAGES-1];

    // Shift the raw asynchronous inputs through the synchronizer chains.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync <= '0;
            dir_sync <= '0;
        end else begin
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_in};
            dir_sync <= {dir_sync[SYNC_STAGES-2:0], dir_in};
        end
    end

    // Next-state and next-output logic; the debounce counter saturates so it never wraps.
    always_comb begin
        state_next  = state;
        db_cnt_next = db_cnt;
        en_next     = 1'b0;
        d_next      = d;
`ifdef STIM_REPEAT_EN
        rep_cnt_next = rep_cnt;
`endif
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next  = PRESS_WAIT;
                    db_cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_next = HELD;
                    en_next    = 1'b1;
                    d_next     = dir_s;
`ifdef STIM_REPEAT_EN
                    rep_cnt_next = '0;
`endif
                end else if (db_cnt != DB_MAX) begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_next  = RELEASE_WAIT;
                    db_cnt_next = '0;
                end
`ifdef STIM_REPEAT_EN
                else if (rep_cnt == REP_LAST) begin
                    en_next      = 1'b1;
                    d_next       = dir_s;
                    rep_cnt_next = '0;
                end else begin
                    rep_cnt_next = rep_cnt + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_next = HELD;
`ifdef STIM_REPEAT_EN
                    rep_cnt_next = '0;
`endif
                end else if (db_cnt == DB_LAST) begin
                    state_next = IDLE;
                end else if (db_cnt != DB_MAX) begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        pressed_next = (state_next == HELD) || (state_next == RELEASE_WAIT);
    end

    // Register the state, counters and all outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            db_cnt  <= '0;
            en      <= 1'b0;
            d       <= 1'b0;
            pressed <= 1'b0;
`ifdef STIM_REPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            state   <= state_next;
            db_cnt  <= db_cnt_next;
            en      <= en_next;
            d       <= d_next;
            pressed <= pressed_next;
`ifdef STIM_REPEAT_EN
            rep_cnt <= rep_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_counter_stim_gen.sv
// tb_counter_stim_gen: directed testbench for counter_stim_gen with default parameters.
// Expected values are hand-derived from edge numbers counted from the first input sample.
module tb_counter_stim_gen;

    logic clk;
    logic reset;
    logic btn_in;
    logic dir_in;
    logic en;
    logic d;
    logic pressed;

    int n_checks;
    int n_fail;

    counter_stim_gen dut (
        .clk     (clk),
        .reset   (reset),
        .btn_in  (btn_in),
        .dir_in  (dir_in),
        .en      (en),
        .d       (d),
        .pressed (pressed)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic b, input logic dv);
        reset  = r;
        btn_in = b;
        dir_in = dv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int e, input logic exp_en,
                               input logic exp_d, input logic exp_pressed);
        n_checks++;
        assert (en === exp_en) else begin
            n_fail++;
            $error("FAIL %s edge %0d en: observed %b expected %b", tag, e, en, exp_en);
        end
        n_checks++;
        assert (d === exp_d) else begin
            n_fail++;
            $error("FAIL %s edge %0d d: observed %b expected %b", tag, e, d, exp_d);
        end
        n_checks++;
        assert (pressed === exp_pressed) else begin
            n_fail++;
            $error("FAIL %s edge %0d pressed: observed %b expected %b", tag, e, pressed, exp_pressed);
        end
    endtask

    // Release from a held state: pressed falls in the cycle after edge 6, d is untouched.
    task automatic releaseAndCheck(input string tag, input logic held_d);
        applyStimulus(1'b0, 1'b0, dir_in);
        for (int e = 0; e < 10; e++) begin
            tick();
            checkOutput(tag, e, 1'b0, held_d, (e < 6));
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        logic [11:0] bounce_pat;
        logic exp_rep;
        n_checks = 0;
        n_fail   = 0;

        $display("[TB] reset held with button and direction high");
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int e = 0; e < 3; e++) begin
            tick();
            checkOutput("reset", e, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] full debounce after reset deassert");
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int e = 0; e < 10; e++) begin
            tick();
            checkOutput("post_reset", e, (e == 6), (e >= 6), (e >= 6));
        end
        releaseAndCheck("post_reset_rel", 1'b1);

        $display("[TB] clean press held for 20 cycles");
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int e = 0; e < 20; e++) begin
            tick();
            checkOutput("clean", e, (e == 6), 1'b1, (e >= 6));
        end
        releaseAndCheck("clean_rel", 1'b1);

        $display("[TB] press bounce rejected");
        bounce_pat = 12'b0000_0011_0111;
        for (int e = 0; e < 12; e++) begin
            applyStimulus(1'b0, bounce_pat[e], 1'b1);
            tick();
            checkOutput("bounce", e, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int e = 0; e < 4; e++) begin
            tick();
            checkOutput("bounce_idle", e, 1'b0, 1'b1, 1'b0);
        end

        $display("[TB] press with direction down, flip direction mid-hold");
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int e = 0; e < 12; e++) begin
            tick();
            checkOutput("dir_down", e, (e == 6), (e < 6), (e >= 6));
            if (e == 7) applyStimulus(1'b0, 1'b1, 1'b1);
        end

        $display("[TB] release glitch while held");
        for (int g = 0; g < 12; g++) begin
            applyStimulus(1'b0, (g >= 2), 1'b1);
            tick();
            checkOutput("glitch", g, 1'b0, 1'b0, 1'b1);
        end
        releaseAndCheck("glitch_rel", 1'b0);

        $display("[TB] next press picks up direction up");
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int e = 0; e < 10; e++) begin
            tick();
            checkOutput("dir_up", e, (e == 6), (e >= 6), (e >= 6));
        end
        releaseAndCheck("dir_up_rel", 1'b1);

        $display("[TB] long hold for 40 cycles");
        for (int e = 0; e < 50; e++) begin
            applyStimulus(1'b0, (e < 40), 1'b1);
            tick();
`ifdef STIM_REPEAT_EN
            exp_rep = (e == 6) || (e == 22) || (e == 38);
`else
            exp_rep = (e == 6);
`endif
            checkOutput("long_hold", e, exp_rep, 1'b1, (e >= 6) && (e < 46));
        end

        $display("[TB] reset mid-hold re-debounces and pulses again");
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int e = 0; e < 9; e++) begin
            tick();
            checkOutput("pre_reset_hold", e, (e == 6), (e < 6), (e >= 6));
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("mid_reset", 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int e = 0; e < 10; e++) begin
            tick();
            checkOutput("re_press", e, (e == 6), (e >= 6), (e >= 6));
        end
        releaseAndCheck("re_press_rel", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
